// File: rtl/unpacked_array_serializer.sv
// Captures an M-lane unpacked bit array and drains it lane 0 first over a valid/ready serial link.
// Optional even-parity trailer beat when UNPACKED_SERIALIZER_PARITY_EN is defined.
module unpacked_array_serializer #(
    parameter int M = 2
) (
    input  logic         clock,
    input  logic         rstn,
    input  logic         load,
    input  logic         din_u [0:M-1],
    output logic         busy,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         sout_last,
    output logic [0:M-1] word_q,
    output logic         overrun
);

    localparam int CNT_W = $clog2(M + 2);
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(M - 1);
`ifdef UNPACKED_SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] PARITY_IDX = CNT_W'(M);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_idx_nxt;
    logic [0:M-1]      r_shadow;
    logic              w_capture;
    logic              w_bit;
    logic              w_xfer;
    logic              w_final;

    // Shadow doubles as the packed snapshot: both change only on an accepted load.
    assign word_q = r_shadow;

    // NOTE: sequential state uses non-blocking assignments only; the shadow bank is
    // reset too, because word_q must read zero after reset.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                for (int i = 0; i < M; i++) r_shadow[i] <= din_u[i];
            end
        end
    end

    // Lane mux by equality compare keeps the index width independent of M.
    always_comb begin
        w_bit = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (r_idx == CNT_W'(i)) w_bit = r_shadow[i];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        busy       = (r_state != S_IDLE);
        sout_valid = (r_state != S_IDLE);
        sout       = 1'b0;
        sout_last  = 1'b0;
        case (r_state)
            S_SHIFT: begin
                sout = w_bit;
`ifndef UNPACKED_SERIALIZER_PARITY_EN
                sout_last = (r_idx == LAST_DATA_IDX);
`endif
            end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
            S_PARITY: begin
                sout      = ^r_shadow;
                sout_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign w_xfer  = sout_valid && sout_ready;
    assign w_final = w_xfer && sout_last;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        overrun     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            default: begin
                if (w_final) begin
                    // A load coinciding with the final transfer restarts without a bubble.
                    w_capture   = load;
                    w_idx_nxt   = '0;
                    w_state_nxt = load ? S_SHIFT : S_IDLE;
                end else begin
                    overrun = load && rstn;
                    if (w_xfer) begin
`ifdef UNPACKED_SERIALIZER_PARITY_EN
                        if (r_idx == LAST_DATA_IDX) begin
                            w_idx_nxt   = PARITY_IDX;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_idx_nxt = r_idx + CNT_W'(1);
                        end
`else
                        w_idx_nxt = r_idx + CNT_W'(1);
`endif
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Self-checking bench: directed scenarios then random load/ready traffic against a
// frame-queue model of the serial stream.
module tb_unpacked_array_serializer;

    localparam int M = 4;

    logic         clock = 1'b0;
    logic         rstn;
    logic         load;
    logic         din_u [0:M-1];
    logic         busy;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready;
    logic         sout_last;
    logic [0:M-1] word_q;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model: the beats still owed in the current frame, and the last snapshot.
    bit           exp_q [$];
    logic [0:M-1] exp_word;

    unpacked_array_serializer #(.M(M)) dut (
        .clock      (clock),
        .rstn       (rstn),
        .load       (load),
        .din_u      (din_u),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .sout_last  (sout_last),
        .word_q     (word_q),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_din(input logic [0:M-1] w);
        for (int i = 0; i < M; i++) din_u[i] = w[i];
    endtask

    task automatic start_frame(input logic [0:M-1] w);
        exp_word = w;
        exp_q.delete();
        for (int i = 0; i < M; i++) exp_q.push_back(w[i]);
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    // One clock cycle: drive inputs just after an edge, check outputs mid-cycle, advance model.
    task automatic cycle(input logic ld, input logic [0:M-1] w, input logic rdy);
        bit active;
        bit fin;
        load       = ld;
        sout_ready = rdy;
        drive_din(w);
        #2;
        active = (exp_q.size() > 0);
        fin    = active && rdy && (exp_q.size() == 1);
        check("sout_valid", sout_valid, active);
        check("busy", busy, active);
        check("word_q", word_q, exp_word);
        check("overrun", overrun, active && ld && !fin);
        if (active) begin
            check("sout", sout, exp_q[0]);
            check("sout_last", sout_last, exp_q.size() == 1);
        end
        @(posedge clock);
        if (active && rdy) void'(exp_q.pop_front());
        if (ld && (!active || fin)) start_frame(w);
        #1;
    endtask

    task automatic reset_cycle(input logic ld);
        rstn = 1'b0;
        load = ld;
        sout_ready = 1'b1;
        @(posedge clock);
        #1;
        rstn = 1'b1;
        load = 1'b0;
        exp_q.delete();
        exp_word = '0;
        #1;
        check("rst_valid", sout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sout", sout, 1'b0);
        check("rst_last", sout_last, 1'b0);
        check("rst_word", word_q, '0);
        check("rst_overrun", overrun, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        load = 1'b0;
        sout_ready = 1'b0;
        drive_din('0);
        exp_word = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_cycle(1'b1);

        // Basic frame, ready always high.
        cycle(1'b1, 4'b1011, 1'b1);
        repeat (5) cycle(1'b0, 4'b0000, 1'b1);

        // Backpressure in the middle of a frame.
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        repeat (4) cycle(1'b0, 4'b0000, 1'b1);

        // Rejected load during a frame.
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        repeat (4) cycle(1'b0, 4'b0000, 1'b1);

        // Back-to-back load on the final-beat transfer.
        cycle(1'b1, 4'b1011, 1'b1);
        while (exp_q.size() > 1) cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b1, 4'b0100, 1'b1);
        repeat (M + 2) cycle(1'b0, 4'b0000, 1'b1);

        // Reset mid-frame, then a clean frame.
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        reset_cycle(1'b0);
        cycle(1'b1, 4'b0110, 1'b1);
        repeat (M + 2) cycle(1'b0, 4'b0000, 1'b1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_cycle($urandom_range(0, 1) == 1);
            end else begin
                cycle($urandom_range(0, 4) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
